// File: rtl/tdm_frame_rx.sv
// ----------------------------------------------------------------------------
// tdm_frame_rx
// Receiving end of a NUM_CH-slot time-division link. Serial DW-bit words arrive
// one per accepted cycle, slot 0 flagged by in_sof. Words are collected in a
// shadow buffer and out_data is updated atomically once per complete frame,
// with slot k landing in out_data[k*DW +: DW].
//
// Optional feature: define TDM_RX_PARITY_EN to add in_par (even parity over
// {in_data, in_par}). A bad-parity word flags frame_err and aborts the frame.
//
// Ports
//   clk         in   system clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   low = inputs ignored, all state frozen
//   in_valid    in   in_data / in_sof valid this cycle
//   in_sof      in   this word is slot 0
//   in_data     in   DW-bit slot word
//   in_par      in   parity bit (TDM_RX_PARITY_EN builds only)
//   err_clr     in   clears frame_err (an error event in the same cycle wins)
//   out_data    out  last complete frame, registered
//   frame_done  out  one-cycle pulse: out_data updated this cycle
//   frame_err   out  sticky frame error flag
//   slot_idx    out  next expected slot (0 in IDLE)
// ----------------------------------------------------------------------------
module tdm_frame_rx #(
    parameter int NUM_CH = 4,
    parameter int DW     = 4,
    localparam int SLOT_W = $clog2(NUM_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic [DW-1:0]          in_data,
`ifdef TDM_RX_PARITY_EN
    input  logic                   in_par,
`endif
    input  logic                   err_clr,
    output logic [NUM_CH*DW-1:0]   out_data,
    output logic                   frame_done,
    output logic                   frame_err,
    output logic [SLOT_W-1:0]      slot_idx
);

    typedef enum logic {IDLE, RECV} state_t;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

    state_t                 state_q, state_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [NUM_CH*DW-1:0]   shadow_q, shadow_d;
    logic [NUM_CH*DW-1:0]   out_q, out_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic accept;
    logic par_ok;

    assign accept = enable & in_valid;

`ifdef TDM_RX_PARITY_EN
    assign par_ok = ~(^{in_data, in_par});
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            shadow_q <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        done_d   = 1'b0;
        // Clear first so that any error event below overrides it.
        err_d    = err_q & ~(enable & err_clr);

        if (accept) begin
            if (!par_ok) begin
                // Corrupt word: abandon whatever was in progress, no resync.
                err_d   = 1'b1;
                slot_d  = '0;
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        // Words outside a frame are silently dropped.
                        if (in_sof) begin
                            shadow_d[DW-1:0] = in_data;
                            slot_d           = SLOT_W'(1);
                            state_d          = RECV;
                        end
                    end
                    RECV: begin
                        if (in_sof) begin
                            // Early start: discard partial frame and resync on this word.
                            err_d            = 1'b1;
                            shadow_d[DW-1:0] = in_data;
                            slot_d           = SLOT_W'(1);
                        end else if (slot_q == LAST_SLOT) begin
                            // Last word bypasses the shadow straight into the output.
                            out_d = shadow_q;
                            out_d[(NUM_CH-1)*DW +: DW] = in_data;
                            done_d  = 1'b1;
                            slot_d  = '0;
                            state_d = IDLE;
                        end else begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (slot_q == SLOT_W'(k)) begin
                                    shadow_d[k*DW +: DW] = in_data;
                                end
                            end
                            slot_d = slot_q + SLOT_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign out_data   = out_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign slot_idx   = slot_q;

endmodule

// File: tb/tb_tdm_frame_rx.sv
// ----------------------------------------------------------------------------
// tb_tdm_frame_rx
// Directed bench for tdm_frame_rx (NUM_CH=4, DW=4). Completed-frame values are
// queued when the last word is driven and popped when frame_done is seen.
// Define TDM_RX_PARITY_EN for both files to exercise the parity build.
// ----------------------------------------------------------------------------
module tb_tdm_frame_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        in_valid;
    logic        in_sof;
    logic [3:0]  in_data;
`ifdef TDM_RX_PARITY_EN
    logic        in_par;
`endif
    logic        err_clr;
    logic [15:0] out_data;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  slot_idx;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    tdm_frame_rx #(.NUM_CH(4), .DW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
`ifdef TDM_RX_PARITY_EN
        .in_par     (in_par),
`endif
        .err_clr    (err_clr),
        .out_data   (out_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .slot_idx   (slot_idx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input (good parity), then return 1 time unit after the edge.
    task automatic step(input logic v, input logic s, input logic [3:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
`ifdef TDM_RX_PARITY_EN
        in_par   = ^d;
`endif
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every frame_done must match the oldest queued frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {16'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                chk("frame_out", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        in_data = 4'h0; err_clr = 1'b0;
`ifdef TDM_RX_PARITY_EN
        in_par = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {16'h0, out_data}, 32'h0);
        chk("rst_done", {31'h0, frame_done}, 32'h0);
        chk("rst_err", {31'h0, frame_err}, 32'h0);
        chk("rst_slot", {30'h0, slot_idx}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Words without sof in IDLE are dropped.
        step(1, 0, 4'h5);
        step(1, 0, 4'h6);
        chk("idle_drop_out", {16'h0, out_data}, 32'h0);
        chk("idle_drop_err", {31'h0, frame_err}, 32'h0);
        chk("idle_drop_slot", {30'h0, slot_idx}, 32'h0);

        // Basic frame.
        step(1, 1, 4'hA);
        chk("slot_after_sof", {30'h0, slot_idx}, 32'h1);
        step(1, 0, 4'hB);
        step(1, 0, 4'hC);
        chk("no_early_update", {16'h0, out_data}, 32'h0);
        exp_q.push_back(16'hDCBA);
        step(1, 0, 4'hD);
        chk("done_pulse", {31'h0, frame_done}, 32'h1);
        chk("frame1_out", {16'h0, out_data}, 32'hDCBA);
        step(0, 0, 4'h0);
        chk("done_one_cycle", {31'h0, frame_done}, 32'h0);
        chk("frame1_err", {31'h0, frame_err}, 32'h0);
        chk("frame1_slot", {30'h0, slot_idx}, 32'h0);

        // Early sof: error, resync, partial discarded.
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 1, 4'h3);
        chk("early_sof_err", {31'h0, frame_err}, 32'h1);
        chk("early_sof_slot", {30'h0, slot_idx}, 32'h1);
        chk("early_sof_out", {16'h0, out_data}, 32'hDCBA);
        step(1, 0, 4'h4);
        step(1, 0, 4'h5);
        exp_q.push_back(16'h6543);
        step(1, 0, 4'h6);
        chk("resync_out", {16'h0, out_data}, 32'h6543);
        step(0, 0, 4'h0);

        // Clear error, then enable gap mid-frame.
        err_clr = 1'b1;
        step(0, 0, 4'h0);
        err_clr = 1'b0;
        chk("err_clear", {31'h0, frame_err}, 32'h0);
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        enable = 1'b0;
        repeat (10) step(1, 0, 4'h7);
        chk("hold_slot", {30'h0, slot_idx}, 32'h2);
        chk("hold_out", {16'h0, out_data}, 32'h6543);
        enable = 1'b1;
        step(1, 0, 4'h3);
        exp_q.push_back(16'h4321);
        step(1, 0, 4'h4);
        chk("resume_out", {16'h0, out_data}, 32'h4321);
        chk("resume_err", {31'h0, frame_err}, 32'h0);
        step(0, 0, 4'h0);

        // err_clr coinciding with an early sof: set wins.
        step(1, 1, 4'h1);
        err_clr = 1'b1;
        step(1, 1, 4'h8);
        chk("set_wins", {31'h0, frame_err}, 32'h1);
        step(0, 0, 4'h0);
        err_clr = 1'b0;
        chk("clr_alone", {31'h0, frame_err}, 32'h0);

        // Asynchronous reset mid-frame (slot_idx is 1 here, take one more word).
        step(1, 0, 4'h9);
        chk("pre_rst_slot", {30'h0, slot_idx}, 32'h2);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", {16'h0, out_data}, 32'h0);
        chk("async_rst_slot", {30'h0, slot_idx}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef TDM_RX_PARITY_EN
        // Good frame, then a frame with bad parity on slot 2.
        step(1, 1, 4'h1);
        step(1, 0, 4'h2);
        step(1, 0, 4'h3);
        exp_q.push_back(16'h4321);
        step(1, 0, 4'h4);
        step(1, 1, 4'h5);
        step(1, 0, 4'h6);
        in_valid = 1'b1; in_sof = 1'b0; in_data = 4'h7; in_par = ~(^4'h7);
        @(posedge clk);
        #1;
        chk("par_err", {31'h0, frame_err}, 32'h1);
        chk("par_slot", {30'h0, slot_idx}, 32'h0);
        step(1, 0, 4'h8);
        chk("par_out", {16'h0, out_data}, 32'h4321);
        chk("par_idle_slot", {30'h0, slot_idx}, 32'h0);
        step(0, 0, 4'h0);
        chk("done_count", done_seen, 32'd4);
`else
        step(0, 0, 4'h0);
        chk("done_count", done_seen, 32'd3);
`endif
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
